spart_driver: RTL



---
 rtl/spart_driver_if.sv | 12 +
 rtl/spart_driver.sv | 131 +++++++++++++
 2 files changed

// File: rtl/spart_driver_if.sv
// SPART bus control/handshake signals between the driver (master) and the SPART (slave).
// The 8-bit data bus is a tri-state net and is carried as a separate inout port.
interface spart_driver_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;

  modport master (output iocs, output iorw, output ioaddr, input rda, input tbr);
  modport slave  (input iocs, input iorw, input ioaddr, output rda, output tbr);
endinterface

// File: rtl/spart_driver.sv
// Processor stand-in on the SPART bus: programs the baud divisor from the switches,
// then echoes every received byte back to the transmitter.
module spart_driver #(
  parameter logic [15:0] DIV_4800  = 16'd650,
  parameter logic [15:0] DIV_9600  = 16'd324,
  parameter logic [15:0] DIV_19200 = 16'd161,
  parameter logic [15:0] DIV_38400 = 16'd80
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          br_cfg,
  spart_driver_if.master      bus,
  inout  wire  [7:0]          databus,
  output logic [7:0]          echo_cnt
);

  typedef enum logic [2:0] {
    INIT,
    CFG_LO,
    CFG_HI,
    IDLE,
    RD,
    WAIT_TBR,
    WR
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  br_meta;
  logic [1:0]  br_sync;
  logic [1:0]  cfg_cur;
  logic [7:0]  rx_byte;
  logic [15:0] div;
  logic        drive_en;
  logic [7:0]  wdata;

  // The bus is only ever driven in write cycles; otherwise it is released.
  assign databus = drive_en ? wdata : 'z;

  // Divisor selected by the configuration latched for the current programming pass.
  always_comb begin
    case (cfg_cur)
      2'b00:   div = DIV_4800;
      2'b01:   div = DIV_9600;
      2'b10:   div = DIV_19200;
      default: div = DIV_38400;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= INIT;
    else     state <= state_nxt;
  end

  // Two-flop synchronizer for the asynchronous switch inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_meta <= '0;
      br_sync <= '0;
    end else begin
      br_meta <= br_cfg;
      br_sync <= br_meta;
    end
  end

  // Datapath: latch config on entry to CFG_LO, capture RX byte, count echoes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_cur  <= '0;
      rx_byte  <= '0;
      echo_cnt <= '0;
    end else begin
      if (state_nxt == CFG_LO && state != CFG_LO) cfg_cur <= br_sync;
      if (state == RD) rx_byte <= databus;
      if (state == WR) echo_cnt <= echo_cnt + 8'd1;
    end
  end

  // Next-state logic and bus outputs decoded from the current state only.
  always_comb begin
    state_nxt  = state;
    bus.iocs   = 1'b0;
    bus.iorw   = 1'b1;
    bus.ioaddr = 2'b00;
    drive_en   = 1'b0;
    wdata      = '0;
    case (state)
      INIT: state_nxt = CFG_LO;
      CFG_LO: begin
        bus.iocs   = 1'b1;
        bus.iorw   = 1'b0;
        bus.ioaddr = 2'b10;
        drive_en   = 1'b1;
        wdata      = div[7:0];
        state_nxt  = CFG_HI;
      end
      CFG_HI: begin
        bus.iocs   = 1'b1;
        bus.iorw   = 1'b0;
        bus.ioaddr = 2'b11;
        drive_en   = 1'b1;
        wdata      = div[15:8];
        state_nxt  = IDLE;
      end
      IDLE: begin
        if (br_sync != cfg_cur) state_nxt = CFG_LO;
        else if (bus.rda)       state_nxt = RD;
      end
      RD: begin
        bus.iocs   = 1'b1;
        bus.iorw   = 1'b1;
        bus.ioaddr = 2'b00;
        state_nxt  = WAIT_TBR;
      end
      WAIT_TBR: begin
        if (bus.tbr) state_nxt = WR;
      end
      WR: begin
        bus.iocs   = 1'b1;
        bus.iorw   = 1'b0;
        bus.ioaddr = 2'b00;
        drive_en   = 1'b1;
        wdata      = rx_byte;
        state_nxt  = IDLE;
      end
      default: state_nxt = INIT;
    endcase
  end

endmodule
